// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus
// the decode-facing instruction channel with backpressure.
interface fetch_pc_unit_if #(
    parameter int unsigned ADDR_WIDTH = 17
) ();
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_inst;
    logic                  inst_valid;
    logic [31:0]           inst_out;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_ready;

    // Fetch unit side: drives requests and instructions.
    modport master (
        output req_valid, req_addr, inst_valid, inst_out, inst_pc,
        input  req_ready, resp_valid, resp_inst, inst_ready
    );

    // Memory/decode side.
    modport slave (
        input  req_valid, req_addr, inst_valid, inst_out, inst_pc,
        output req_ready, resp_valid, resp_inst, inst_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch program counter and single-outstanding fetch sequencer.
// Issues one memory request at a time, hands the returned word to decode,
// steps by 2 or 4 bytes, and drops responses made stale by a redirect.
module fetch_pc_unit #(
    parameter int unsigned           ADDR_WIDTH = 17,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter bit                    C_EXT      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  flush_en,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_pc,
    fetch_pc_unit_if.master       fetch
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  discard_q, discard_d;
    logic [31:0]           inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  req_valid_q, req_valid_d;
    logic                  inst_valid_q, inst_valid_d;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] next_pc;

    // Next-state, next-PC and registered-output computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        next_pc    = pc_q;

        redirect = flush_en | jump_en;
        target   = flush_en ? flush_pc : jump_pc;
        step     = (C_EXT && (inst_q[1:0] != 2'b11)) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);

        case (state_q)
            IDLE: begin
                next_pc = redirect ? target : pc_q;
                pc_d    = next_pc;
                if (!stall_in) begin
                    state_d    = REQ;
                    req_addr_d = next_pc;
                end
            end
            REQ: begin
                // The issued address stays on the bus; a redirect only
                // retargets pc and marks the coming response stale.
                if (redirect) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
                if (fetch.req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (fetch.resp_valid) begin
                    if (!discard_q && !redirect) begin
                        inst_d    = fetch.resp_inst;
                        inst_pc_d = req_addr_q;
                        state_d   = HOLD;
                    end else begin
                        discard_d = 1'b0;
                        next_pc   = redirect ? target : pc_q;
                        pc_d      = next_pc;
                        if (stall_in) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = REQ;
                            req_addr_d = next_pc;
                        end
                    end
                end else if (redirect) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                // Redirect wins over the sequential step even when decode
                // consumes the instruction in the same cycle.
                if (redirect || fetch.inst_ready) begin
                    next_pc = redirect ? target : (inst_pc_q + step);
                    pc_d    = next_pc;
                    if (stall_in) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = REQ;
                        req_addr_d = next_pc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_valid_d  = (state_d == REQ);
        inst_valid_d = (state_d == HOLD);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, request and held-instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            discard_q    <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            discard_q    <= discard_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign fetch.req_valid  = req_valid_q;
    assign fetch.req_addr   = req_addr_q;
    assign fetch.inst_valid = inst_valid_q;
    assign fetch.inst_out   = inst_q;
    assign fetch.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: two instances (C_EXT=1 and C_EXT=0) driven by
// directed steps and then randomized traffic, checked every cycle against a
// transaction-level reference model.
module tb_fetch_pc_unit;

    localparam int unsigned       AW     = 17;
    localparam logic [AW-1:0]     RST_PC = 17'h00100;

    logic          clk;
    logic          rst;
    logic          stall_in;
    logic          flush_en;
    logic [AW-1:0] flush_pc;
    logic          jump_en;
    logic [AW-1:0] jump_pc;

    logic          rdy_in  [2];
    logic          rv_in   [2];
    logic [31:0]   ri_in   [2];
    logic          irdy_in [2];

    int errors = 0;
    int checks = 0;

    fetch_pc_unit_if #(.ADDR_WIDTH(AW)) b0 ();
    fetch_pc_unit_if #(.ADDR_WIDTH(AW)) b1 ();

    assign b0.req_ready  = rdy_in[0];
    assign b0.resp_valid = rv_in[0];
    assign b0.resp_inst  = ri_in[0];
    assign b0.inst_ready = irdy_in[0];
    assign b1.req_ready  = rdy_in[1];
    assign b1.resp_valid = rv_in[1];
    assign b1.resp_inst  = ri_in[1];
    assign b1.inst_ready = irdy_in[1];

    fetch_pc_unit #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC), .C_EXT(1'b1)) u0 (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .flush_en(flush_en), .flush_pc(flush_pc),
        .jump_en(jump_en), .jump_pc(jump_pc), .fetch(b0)
    );

    fetch_pc_unit #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC), .C_EXT(1'b0)) u1 (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .flush_en(flush_en), .flush_pc(flush_pc),
        .jump_en(jump_en), .jump_pc(jump_pc), .fetch(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: observable registers plus "request outstanding" and
    // "response is stale" flags; phase is implied by which flag is set.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] req_addr;
        logic [AW-1:0] inst_pc;
        logic [31:0]   inst;
        logic          req_valid;
        logic          waiting;
        logic          discard;
        logic          inst_valid;
    } mstate_t;

    mstate_t m [2];

    function automatic mstate_t model_reset();
        mstate_t s;
        s.pc = RST_PC; s.req_addr = RST_PC; s.inst_pc = RST_PC; s.inst = '0;
        s.req_valid = 1'b0; s.waiting = 1'b0; s.discard = 1'b0; s.inst_valid = 1'b0;
        return s;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input bit c_ext,
                                           input bit rdy, input bit rv,
                                           input logic [31:0] ri, input bit irdy);
        mstate_t       n;
        bit            redir;
        logic [AW-1:0] tgt;
        bit            launch;
        n      = s;
        redir  = flush_en || jump_en;
        tgt    = flush_en ? flush_pc : jump_pc;
        launch = 1'b0;
        if (s.req_valid) begin
            if (redir) begin n.pc = tgt; n.discard = 1'b1; end
            if (rdy) begin n.req_valid = 1'b0; n.waiting = 1'b1; end
        end else if (s.waiting) begin
            if (rv) begin
                n.waiting = 1'b0;
                if (!s.discard && !redir) begin
                    n.inst_valid = 1'b1; n.inst = ri; n.inst_pc = s.req_addr;
                end else begin
                    n.discard = 1'b0;
                    if (redir) n.pc = tgt;
                    launch = 1'b1;
                end
            end else if (redir) begin
                n.pc = tgt; n.discard = 1'b1;
            end
        end else if (s.inst_valid) begin
            if (redir || irdy) begin
                n.inst_valid = 1'b0;
                if (redir) n.pc = tgt;
                else n.pc = s.inst_pc + ((c_ext && s.inst[1:0] != 2'b11) ? 17'd2 : 17'd4);
                launch = 1'b1;
            end
        end else begin
            if (redir) n.pc = tgt;
            launch = 1'b1;
        end
        if (launch && !stall_in) begin
            n.req_valid = 1'b1;
            n.req_addr  = n.pc;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_req_valid", i),  i ? 32'(b1.req_valid)  : 32'(b0.req_valid),  32'(m[i].req_valid));
            check($sformatf("d%0d_req_addr", i),   i ? 32'(b1.req_addr)   : 32'(b0.req_addr),   32'(m[i].req_addr));
            check($sformatf("d%0d_inst_valid", i), i ? 32'(b1.inst_valid) : 32'(b0.inst_valid), 32'(m[i].inst_valid));
            check($sformatf("d%0d_inst_out", i),   i ? b1.inst_out        : b0.inst_out,        m[i].inst);
            check($sformatf("d%0d_inst_pc", i),    i ? 32'(b1.inst_pc)    : 32'(b0.inst_pc),    32'(m[i].inst_pc));
        end
    endtask

    // Advance one clock: model steps on the same inputs, outputs sampled 1ns later.
    task automatic tick();
        mstate_t nx [2];
        for (int i = 0; i < 2; i++) begin
            nx[i] = rst ? model_next(m[i], (i == 0), rdy_in[i], rv_in[i], ri_in[i], irdy_in[i])
                        : model_reset();
        end
        @(posedge clk);
        m = nx;
        #1;
        check_model();
    endtask

    // Zero-wait memory and always-ready decode; response only when owed.
    task automatic fast(input int n, input logic [31:0] inst);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 2; i++) begin
                rdy_in[i] = 1'b1; irdy_in[i] = 1'b1; ri_in[i] = inst;
                rv_in[i]  = m[i].waiting;
            end
            tick();
        end
    endtask

    task automatic set_mem(input bit rdy, input bit rv, input logic [31:0] ri, input bit irdy);
        for (int i = 0; i < 2; i++) begin
            rdy_in[i] = rdy; rv_in[i] = rv; ri_in[i] = ri; irdy_in[i] = irdy;
        end
    endtask

    initial begin
        rst = 1'b0; stall_in = 1'b0;
        flush_en = 1'b0; flush_pc = '0; jump_en = 1'b0; jump_pc = '0;
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        m[0] = model_reset(); m[1] = model_reset();

        // Reset values
        @(negedge clk);
        check("rst_req_valid", 32'(b0.req_valid), 32'd0);
        check("rst_inst_valid", 32'(b0.inst_valid), 32'd0);
        check("rst_req_addr", 32'(b0.req_addr), 32'h100);
        check("rst_inst_pc", 32'(b0.inst_pc), 32'h100);
        check("rst_inst_out", b0.inst_out, 32'h0);
        tick();
        rst = 1'b1;

        // Boot sequence with zero-wait memory: one instruction every 3 cycles
        for (int k = 0; k < 9; k++) begin
            fast(1, 32'h0000_0013);
            check($sformatf("boot_inst_valid_%0d", k), 32'(b0.inst_valid), 32'((k % 3) == 2));
            if ((k % 3) == 0) begin
                check($sformatf("boot_req_addr_%0d", k), 32'(b0.req_addr), 32'h100 + 32'(4 * (k / 3)));
                check($sformatf("boot_req_valid_%0d", k), 32'(b0.req_valid), 32'd1);
            end
            if ((k % 3) == 2)
                check($sformatf("boot_inst_pc_%0d", k), 32'(b0.inst_pc), 32'h100 + 32'(4 * (k / 3)));
        end

        // Compressed step: jump out of reset to 0x200, fetch 0x4501
        rst = 1'b0; m[0] = model_reset(); m[1] = model_reset();
        tick();
        rst = 1'b1; jump_en = 1'b1; jump_pc = 17'h00200;
        fast(1, 32'h0000_4501);
        check("cext_first_addr", 32'(b0.req_addr), 32'h200);
        jump_en = 1'b0;
        fast(2, 32'h0000_4501);
        check("cext_inst_out", b0.inst_out, 32'h0000_4501);
        fast(1, 32'h0000_4501);
        check("cext1_next_addr", 32'(b0.req_addr), 32'h202);
        check("cext0_next_addr", 32'(b1.req_addr), 32'h204);

        // Jump while waiting: stale response dropped, refetch at 0x400
        fast(1, 32'h0000_0013);
        set_mem(1'b1, 1'b0, 32'h0000_0013, 1'b1);
        jump_en = 1'b1; jump_pc = 17'h00400;
        tick();
        jump_en = 1'b0;
        set_mem(1'b1, 1'b1, 32'h0000_0013, 1'b1);
        tick();
        check("jump_wait_inst_valid", 32'(b0.inst_valid), 32'd0);
        check("jump_wait_addr", 32'(b0.req_addr), 32'h400);
        check("jump_wait_req_valid", 32'(b0.req_valid), 32'd1);

        // Flush and jump together in HOLD with inst_ready: flush wins
        fast(2, 32'h0000_0013);
        check("hold_inst_pc", 32'(b0.inst_pc), 32'h400);
        set_mem(1'b1, 1'b0, 32'h0000_0013, 1'b1);
        flush_en = 1'b1; flush_pc = 17'h00080; jump_en = 1'b1; jump_pc = 17'h00400;
        tick();
        flush_en = 1'b0; jump_en = 1'b0;
        check("flush_inst_valid", 32'(b0.inst_valid), 32'd0);
        check("flush_addr", 32'(b0.req_addr), 32'h80);

        // Memory backpressure: request held stable
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_req_valid_%0d", k), 32'(b0.req_valid), 32'd1);
            check($sformatf("bp_req_addr_%0d", k), 32'(b0.req_addr), 32'h80);
        end

        // Stall in HOLD: handshake completes, no new request until stall drops
        fast(2, 32'h0000_0013);
        stall_in = 1'b1;
        fast(1, 32'h0000_0013);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_req_valid_%0d", k), 32'(b0.req_valid), 32'd0);
            fast(1, 32'h0000_0013);
        end
        stall_in = 1'b0;
        fast(1, 32'h0000_0013);
        check("unstall_addr", 32'(b0.req_addr), 32'h84);

        // Address wrap at 2^17
        fast(2, 32'h0000_0013);
        jump_en = 1'b1; jump_pc = 17'h1FFFC;
        fast(1, 32'h0000_0013);
        jump_en = 1'b0;
        check("wrap_start", 32'(b0.req_addr), 32'h1FFFC);
        fast(3, 32'h0000_0013);
        check("wrap_addr_d0", 32'(b0.req_addr), 32'h0);
        check("wrap_addr_d1", 32'(b1.req_addr), 32'h0);

        // Asynchronous reset in WAIT, late response afterwards is ignored
        fast(1, 32'h0000_0013);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m[0] = model_reset(); m[1] = model_reset();
        check("async_req_valid", 32'(b0.req_valid), 32'd0);
        check("async_req_addr", 32'(b0.req_addr), 32'h100);
        check("async_inst_valid", 32'(b0.inst_valid), 32'd0);
        set_mem(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        set_mem(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("late_req_addr", 32'(b0.req_addr), 32'h100);
        check("late_inst_valid0", 32'(b0.inst_valid), 32'd0);
        tick();
        check("late_inst_valid1", 32'(b0.inst_valid), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            stall_in = ($urandom_range(0, 4) == 0);
            flush_en = ($urandom_range(0, 19) == 0);
            jump_en  = ($urandom_range(0, 11) == 0);
            flush_pc = AW'($urandom);
            jump_pc  = ($urandom_range(0, 3) == 0) ? (17'h1FFFA + AW'($urandom_range(0, 5))) : AW'($urandom);
            for (int i = 0; i < 2; i++) begin
                logic [31:0] w;
                w = $urandom;
                if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
                ri_in[i]   = w;
                rdy_in[i]  = ($urandom_range(0, 9) < 6);
                irdy_in[i] = ($urandom_range(0, 9) < 6);
                rv_in[i]   = m[i].waiting ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised fetch-side program counter and single-outstanding instruction-fetch sequencer. It sits between the commit/decode redirect sources and the instruction memory port. It issues fetch requests over a valid/ready handshake and presents fetched instructions to decode with backpressure. It supports 2-byte steps for compressed instructions and drops stale responses after a redirect.

## Interface
- ADDR_WIDTH, 17, width of all PC/address signals
- RESET_PC, 0, PC value loaded on reset
- C_EXT, 1, 1: step 2 when inst[1:0]!=2'b11; 0: always step 4
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- stall_in  in  1  blocks issuing new fetch requests
- flush_en  in  1  commit redirect (highest priority)
- flush_pc  in  ADDR_WIDTH  commit redirect target
- jump_en  in  1  decode redirect
- jump_pc  in  ADDR_WIDTH  decode redirect target
- req_valid  out  1  fetch request valid
- req_addr  out  ADDR_WIDTH  fetch address
- req_ready  in  1  memory accepts request
- resp_valid  in  1  fetch response valid, exactly one per accepted request
- resp_inst  in  32  fetched word
- inst_valid  out  1  instruction valid to decode
- inst_out  out  32  instruction
- inst_pc  out  ADDR_WIDTH  PC of inst_out
- inst_ready  in  1  decode accepts instruction

## Operation
- Registers: pc, req_addr, discard flag, held instruction/PC, state.
- States:
  - IDLE: no request.
  - REQ: req_valid=1.
  - WAIT: request accepted, response pending.
  - HOLD: inst_valid=1.
- Redirect: redirect = flush_en | jump_en; target = flush_en ? flush_pc : jump_pc. Flush beats jump.
- IDLE:
  - Redirect loads pc <= target.
  - If !stall_in, go to REQ with req_addr <= target or pc.
- REQ:
  - req_addr and req_valid hold until req_valid & req_ready; then go to WAIT.
  - An issued request is never withdrawn.
  - Redirect in REQ: pc <= target, discard <= 1; req_addr is unchanged.
- WAIT:
  - On resp_valid with discard=0 and no redirect: latch resp_inst and req_addr, go to HOLD.
  - On resp_valid with discard=1 or a redirect: drop the response, clear discard, pc <= target (if redirect), go to REQ at pc (IDLE if stall_in).
  - Redirect without resp_valid: pc <= target, discard <= 1.
- HOLD:
  - On inst_ready: pc <= inst_pc + step, go to REQ (IDLE if stall_in).
  - Redirect: inst_valid drops next cycle, pc <= target, go to REQ/IDLE. Redirect overrides the step even when inst_ready is high the same cycle (that instruction counts as consumed).
- step = (C_EXT && inst_out[1:0]!=2'b11) ? 2 : 4.
- Addition is modulo 2^ADDR_WIDTH and wraps silently. There is no alignment check.
- stall_in never cancels a pending REQ, WAIT or HOLD; it only blocks the IDLE->REQ and HOLD/WAIT->REQ transitions.
- Response ordering: at most one request outstanding. A resp_valid in IDLE, REQ or HOLD is ignored.

## Timing
- All outputs are registered. Reset values:
  - req_valid=0, inst_valid=0
  - req_addr=RESET_PC, inst_pc=RESET_PC, inst_out=0
  - pc=RESET_PC, discard=0, state=IDLE
- Reset is asynchronous and takes effect mid-transaction. Any outstanding response arriving after reset release is ignored because state is IDLE/REQ.
- First request: req_valid=1 in the first cycle after reset release, given stall_in=0.
- Latencies:
  - resp_valid -> inst_valid: 1 cycle.
  - inst_ready handshake -> req_valid: 1 cycle.
  - Redirect -> request to target: 1 cycle from IDLE/HOLD; from REQ/WAIT, 1 cycle after the stale response.
- Best-case throughput with 0-wait memory (ready=1, response next cycle): 1 instruction per 3 cycles.

## Test plan
- Reset, no stall, req_ready=1, 1-cycle memory returning 0x00000013; RESET_PC=0x100 -> req_addr sequence 0x100, 0x104, 0x108; inst_pc matches; inst_valid every 3rd cycle.
- C_EXT=1, response 0x00004501 (inst[1:0]=01) at 0x200 -> next req_addr 0x202; with C_EXT=0 -> 0x204.
- Assert jump_en=1, jump_pc=0x400 in WAIT, then respond -> response dropped, inst_valid stays 0, next req_addr=0x400.
- flush_en (0x80) and jump_en (0x400) together in HOLD with inst_ready=1 -> inst_valid 0 next cycle, next req_addr=0x80.
- req_ready=0 for 5 cycles -> req_valid and req_addr stable throughout. stall_in=1 in HOLD -> after handshake state IDLE, no request until stall_in drops.
- ADDR_WIDTH=17, pc=0x1FFFC, 4-byte instruction -> next req_addr=0x00000. Drive rst low during WAIT, then a late resp_valid -> ignored, req_addr=RESET_PC.
